register_renamer_ckpt: RTL and testbench
========================================

REGISTER_RENAMER_CKPT -- requirements
Module: register_renamer_ckpt

Interface
REQ-001 SHALL have parameter NUM_A_REGS, default 32, number of architectural registers; register 0 is hard-wired zero.
REQ-002 SHALL have parameter NUM_P_REGS, default 64, number of physical registers; NUM_P_REGS > NUM_A_REGS.
REQ-003 SHALL have parameter WIDTH, default 2, number of rename lanes per cycle.
REQ-004 SHALL have parameter NUM_CKPT, default 4, number of branch checkpoints.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk_i and rst_i.
REQ-006 SHALL have ports (AW=$clog2(NUM_A_REGS), PW=$clog2(NUM_P_REGS), CW=$clog2(NUM_CKPT)):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ren_valid_i  in  WIDTH  per-lane rename request; lane 0 is oldest
- rd_i / rs1_i / rs2_i  in  WIDTH*AW each  architectural dest and sources per lane
- ren_ready_o  out  1  group accepted this cycle
- p_dest_o / old_dest_o / p_rs1_o / p_rs2_o  out  WIDTH*PW each  renamed operands per lane
- free_valid_i  in  WIDTH  commit-time release per lane
- free_preg_i  in  WIDTH*PW  physical registers to return
- ckpt_take_i  in  1  snapshot state after this cycle's group
- ckpt_id_o  out  CW  id assigned to the snapshot
- ckpt_full_o  out  1  all NUM_CKPT checkpoints in use
- ckpt_release_i  in  1  retire the oldest checkpoint (branch correct)
- recover_i / recover_id_i  in  1 / CW  mispredict rollback to that checkpoint
- free_count_o  out  PW+1  free physical registers

Function
REQ-007 Map table (RAT) SHALL map each architectural register to a physical register; RAT[0] is always 0.
REQ-008 Free list SHALL be a circular FIFO of depth NUM_P_REGS with head/tail pointers carrying one wrap bit; free_count_o = tail - head.
REQ-009 Lane needs allocation iff ren_valid_i[k] && rd_i[k] != 0; such a lane SHALL take the next free-list entry in lane order; p_dest_o = 0 and no allocation for rd 0.
REQ-010 Lookups SHALL be combinational in the request cycle; state updates at the next rising edge.
REQ-011 Intra-group bypass: p_rs1/p_rs2/old_dest of lane k SHALL reflect the youngest allocating lane j<k with matching rd, else the RAT.
REQ-012 ren_ready_o SHALL be low, with no RAT/free-list change, when allocations needed > free_count_o, when recover_i is high, or when ckpt_take_i && ckpt_full_o.
REQ-013 Two lanes with the same rd in one group: the RAT SHALL keep the younger lane's mapping.
REQ-014 Frees SHALL push valid free_preg_i entries to the tail in lane order; freed registers are not allocatable until the next cycle; frees apply even during a stall or recovery.
REQ-015 Checkpoints SHALL be a circular queue; a take on an accepted cycle stores the post-group RAT and head pointer, and ckpt_id_o reports the allocated slot in that cycle.
REQ-016 ckpt_release_i SHALL free the oldest slot and is ignored when the queue is empty.
REQ-017 recover_i SHALL restore the RAT and head from recover_id_i, discard that slot and all younger slots, and drop the current rename group.
REQ-018 recover_i SHALL take priority over ckpt_take_i and ckpt_release_i in the same cycle.

Reset
REQ-019 On rst_i: RAT[i]=i; free list holds NUM_A_REGS..NUM_P_REGS-1 in order; free_count_o = NUM_P_REGS-NUM_A_REGS; checkpoint queue empty; ckpt_full_o=0; ckpt_id_o=0.
REQ-020 rst_i mid-operation SHALL override every other input in that cycle.

Verification
REQ-021 After reset: rd={1,2}, both valid -> p_dest={32,33}, old_dest={1,2}, ren_ready_o=1, free_count_o=30 on the next cycle.
REQ-022 Next cycle: rd={3,3}, rs1={1,3} -> p_rs1={32,34}, p_dest={34,35}, old_dest={3,34}; then RAT[3]=35.
REQ-023 rd={0,4} -> p_dest={0,36}, only one entry allocated; free_count_o drops by 1.
REQ-024 Drain to free_count_o=1, then request a 2-allocation group -> ren_ready_o=0 and no state change; free_valid_i={1,0} with free_preg_i=32 -> group accepted on the following cycle.
REQ-025 Take a checkpoint with rd={5,6} (ckpt_id_o=0), rename rd={5,7}, then recover_i with id 0 -> RAT[5], RAT[7] and free_count_o equal their post-checkpoint values; queue empty.
REQ-026 Take 4 checkpoints -> ckpt_full_o=1; a 5th take stalls the group; ckpt_release_i -> ckpt_full_o=0; assert rst_i mid-sequence -> all REQ-019 values.

Source files
------------

// File: rtl/register_renamer_ckpt_if.sv
// Rename port bundle: request/response lanes, commit-time frees and
// checkpoint control. Signal suffixes are relative to the renamer (slave).
//
// Handshake: ren_valid_i is a per-lane request (lane 0 oldest) and
// ren_ready_o is a single group-level acknowledge computed combinationally
// from the same cycle's inputs. Lane k is consumed at the rising edge
// where ren_valid_i[k] && ren_ready_o. When ren_ready_o is low the whole
// group is refused, and the master holds it (or withdraws it after a
// recovery). Frees and checkpoint releases are fire-and-forget strobes.
interface register_renamer_ckpt_if #(
   parameter int NUM_A_REGS = 32,
   parameter int NUM_P_REGS = 64,
   parameter int WIDTH      = 2,
   parameter int NUM_CKPT   = 4
);
   localparam int AW = $clog2(NUM_A_REGS);
   localparam int PW = $clog2(NUM_P_REGS);
   localparam int CW = $clog2(NUM_CKPT);

   logic [WIDTH-1:0]    ren_valid_i;
   logic [WIDTH*AW-1:0] rd_i;
   logic [WIDTH*AW-1:0] rs1_i;
   logic [WIDTH*AW-1:0] rs2_i;
   logic                ren_ready_o;
   logic [WIDTH*PW-1:0] p_dest_o;
   logic [WIDTH*PW-1:0] old_dest_o;
   logic [WIDTH*PW-1:0] p_rs1_o;
   logic [WIDTH*PW-1:0] p_rs2_o;
   logic [WIDTH-1:0]    free_valid_i;
   logic [WIDTH*PW-1:0] free_preg_i;
   logic                ckpt_take_i;
   logic [CW-1:0]       ckpt_id_o;
   logic                ckpt_full_o;
   logic                ckpt_release_i;
   logic                recover_i;
   logic [CW-1:0]       recover_id_i;
   logic [PW:0]         free_count_o;

   modport slave (
      input  ren_valid_i, rd_i, rs1_i, rs2_i,
      output ren_ready_o, p_dest_o, old_dest_o, p_rs1_o, p_rs2_o,
      input  free_valid_i, free_preg_i,
      input  ckpt_take_i, ckpt_release_i, recover_i, recover_id_i,
      output ckpt_id_o, ckpt_full_o, free_count_o
   );

   modport master (
      output ren_valid_i, rd_i, rs1_i, rs2_i,
      input  ren_ready_o, p_dest_o, old_dest_o, p_rs1_o, p_rs2_o,
      output free_valid_i, free_preg_i,
      output ckpt_take_i, ckpt_release_i, recover_i, recover_id_i,
      input  ckpt_id_o, ckpt_full_o, free_count_o
   );
endinterface

// File: rtl/register_renamer_ckpt.sv
// Multi-lane register renamer: RAT + circular free list + branch checkpoint
// queue holding RAT/free-list-head snapshots for mispredict recovery.
// NUM_P_REGS and NUM_CKPT are expected to be powers of two so the wrap-bit
// pointer arithmetic of both circular structures is exact.
module register_renamer_ckpt #(
   parameter int NUM_A_REGS = 32,
   parameter int NUM_P_REGS = 64,
   parameter int WIDTH      = 2,
   parameter int NUM_CKPT   = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   register_renamer_ckpt_if.slave rn
);
   localparam int AW = $clog2(NUM_A_REGS);
   localparam int PW = $clog2(NUM_P_REGS);
   localparam int CW = $clog2(NUM_CKPT);

   localparam logic [PW:0] P_ONE     = (PW+1)'(1);
   localparam logic [PW:0] FREE_INIT = (PW+1)'(NUM_P_REGS - NUM_A_REGS);
   localparam logic [CW:0] C_ONE     = (CW+1)'(1);
   localparam logic [CW:0] C_FULL    = (CW+1)'(NUM_CKPT);

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic [PW-1:0] rat_q [NUM_A_REGS];
   logic [PW-1:0] rat_d [NUM_A_REGS];
   logic [PW-1:0] fl_q  [NUM_P_REGS];
   logic [PW:0]   head_q, head_d;
   logic [PW:0]   tail_q, tail_d;

   // checkpoint slots: saved RAT and saved free-list head
   logic [PW-1:0] ck_rat_q  [NUM_CKPT][NUM_A_REGS];
   logic [PW:0]   ck_head_q [NUM_CKPT];
   // checkpoint queue pointers with wrap bit; cq_head_q is the oldest slot
   logic [CW:0]   cq_head_q, cq_head_d;
   logic [CW:0]   cq_tail_q, cq_tail_d;

   // ---------------------------------------------------------------
   // Per-lane views of the flat buses
   // ---------------------------------------------------------------
   logic [AW-1:0] rd    [WIDTH];
   logic [AW-1:0] rs1   [WIDTH];
   logic [AW-1:0] rs2   [WIDTH];
   logic [PW-1:0] fpreg [WIDTH];

   logic [WIDTH-1:0] alloc;
   logic [PW:0]      alloc_cnt;
   logic [PW-1:0]    p_dest   [WIDTH];
   logic [PW-1:0]    old_dest [WIDTH];
   logic [PW-1:0]    p_rs1    [WIDTH];
   logic [PW-1:0]    p_rs2    [WIDTH];

   logic [PW-1:0]    free_idx [WIDTH];
   logic [PW:0]      free_cnt;

   logic [PW:0]      free_count;
   logic [CW:0]      cq_count;
   logic             ckpt_full;
   logic             accept;
   logic             ck_push;
   logic             ck_pop;
   logic [CW-1:0]    rec_off;

   // Split the packed lane buses into arrays.
   always_comb begin
      for (int k = 0; k < WIDTH; k++) begin
         rd[k]    = rn.rd_i[k*AW +: AW];
         rs1[k]   = rn.rs1_i[k*AW +: AW];
         rs2[k]   = rn.rs2_i[k*AW +: AW];
         fpreg[k] = rn.free_preg_i[k*PW +: PW];
      end
   end

   // Hand out free-list entries to allocating lanes in lane order.
   always_comb begin
      alloc_cnt = '0;
      for (int k = 0; k < WIDTH; k++) begin
         alloc[k]  = rn.ren_valid_i[k] && (rd[k] != '0);
         p_dest[k] = '0;
         if (alloc[k]) begin
            p_dest[k] = fl_q[head_q[PW-1:0] + alloc_cnt[PW-1:0]];
            alloc_cnt = alloc_cnt + P_ONE;
         end
      end
   end

   // Source/old-dest lookup with bypass from the youngest older lane writing the same rd.
   always_comb begin
      for (int k = 0; k < WIDTH; k++) begin
         p_rs1[k]    = rat_q[rs1[k]];
         p_rs2[k]    = rat_q[rs2[k]];
         old_dest[k] = rat_q[rd[k]];
         for (int j = 0; j < k; j++) begin
            if (alloc[j] && rd[j] == rs1[k]) p_rs1[k]    = p_dest[j];
            if (alloc[j] && rd[j] == rs2[k]) p_rs2[k]    = p_dest[j];
            if (alloc[j] && rd[j] == rd[k])  old_dest[k] = p_dest[j];
         end
      end
   end

   // Group acceptance and checkpoint queue bookkeeping.
   always_comb begin
      free_count = tail_q - head_q;
      cq_count   = cq_tail_q - cq_head_q;
      ckpt_full  = (cq_count == C_FULL);
      accept     = !rn.recover_i
                   && !(rn.ckpt_take_i && ckpt_full)
                   && (alloc_cnt <= free_count);
      ck_push    = accept && rn.ckpt_take_i;
      ck_pop     = !rn.recover_i && rn.ckpt_release_i && (cq_count != '0);
      rec_off    = rn.recover_id_i - cq_head_q[CW-1:0];
   end

   // Next RAT and free-list head: recovery restores a snapshot, otherwise the accepted group commits.
   always_comb begin
      rat_d  = rat_q;
      head_d = head_q;
      if (rn.recover_i) begin
         rat_d  = ck_rat_q[rn.recover_id_i];
         head_d = ck_head_q[rn.recover_id_i];
      end else if (accept) begin
         // lane order: a younger lane with the same rd overwrites an older one
         for (int k = 0; k < WIDTH; k++) begin
            if (alloc[k]) rat_d[rd[k]] = p_dest[k];
         end
         head_d = head_q + alloc_cnt;
      end
      rat_d[0] = '0;
   end

   // Tail slots for this cycle's frees; they apply regardless of stall or recovery.
   always_comb begin
      free_cnt = '0;
      for (int k = 0; k < WIDTH; k++) begin
         free_idx[k] = tail_q[PW-1:0] + free_cnt[PW-1:0];
         if (rn.free_valid_i[k]) free_cnt = free_cnt + P_ONE;
      end
      tail_d = tail_q + free_cnt;
   end

   // Next checkpoint queue pointers; recovery truncates at the recovered slot.
   always_comb begin
      cq_head_d = cq_head_q;
      cq_tail_d = cq_tail_q;
      if (rn.recover_i) begin
         cq_tail_d = cq_head_q + {1'b0, rec_off};
      end else begin
         if (ck_push) cq_tail_d = cq_tail_q + C_ONE;
         if (ck_pop)  cq_head_d = cq_head_q + C_ONE;
      end
   end

   // RAT register: identity mapping out of reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_A_REGS; i++) rat_q[i] <= PW'(i);
      end else begin
         rat_q <= rat_d;
      end
   end

   // Free-list storage and pointers: reset fills it with the unmapped registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_P_REGS; i++) begin
            fl_q[i] <= (i < NUM_P_REGS - NUM_A_REGS) ? PW'(i + NUM_A_REGS) : '0;
         end
         head_q <= '0;
         tail_q <= FREE_INIT;
      end else begin
         for (int k = 0; k < WIDTH; k++) begin
            if (rn.free_valid_i[k]) fl_q[free_idx[k]] <= fpreg[k];
         end
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Snapshot storage: captures the post-group RAT and head on an accepted take.
   always_ff @(posedge clk_i) begin
      if (!rst_i && ck_push) begin
         ck_rat_q[cq_tail_q[CW-1:0]]  <= rat_d;
         ck_head_q[cq_tail_q[CW-1:0]] <= head_d;
      end
   end

   // Checkpoint queue pointer registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cq_head_q <= '0;
         cq_tail_q <= '0;
      end else begin
         cq_head_q <= cq_head_d;
         cq_tail_q <= cq_tail_d;
      end
   end

   // Pack per-lane results and status onto the interface.
   always_comb begin
      for (int k = 0; k < WIDTH; k++) begin
         rn.p_dest_o[k*PW +: PW]   = p_dest[k];
         rn.old_dest_o[k*PW +: PW] = old_dest[k];
         rn.p_rs1_o[k*PW +: PW]    = p_rs1[k];
         rn.p_rs2_o[k*PW +: PW]    = p_rs2[k];
      end
      rn.ren_ready_o  = accept;
      rn.free_count_o = free_count;
      rn.ckpt_full_o  = ckpt_full;
      rn.ckpt_id_o    = cq_tail_q[CW-1:0];
   end
endmodule

// File: tb/tb_register_renamer_ckpt.sv
// Directed bench for register_renamer_ckpt: a table of {inputs, expected}
// records applied one per cycle, a drain loop, and a mid-run reset.
module tb_register_renamer_ckpt;
   localparam int NA = 32;
   localparam int NP = 64;
   localparam int W  = 2;
   localparam int NC = 4;
   localparam int AW = 5;
   localparam int PW = 6;
   localparam int CW = 2;

   typedef struct {
      logic [1:0]         valid;
      logic [1:0][AW-1:0] rd;
      logic [1:0][AW-1:0] rs1;
      logic [1:0][AW-1:0] rs2;
      logic [1:0]         fv;
      logic [1:0][PW-1:0] fp;
      logic               take;
      logic               rel;
      logic               rec;
      logic [CW-1:0]      rid;
      logic               chk_ops;
      logic               e_ready;
      logic [1:0][PW-1:0] e_pdest;
      logic [1:0][PW-1:0] e_old;
      logic [1:0][PW-1:0] e_rs1;
      logic [1:0][PW-1:0] e_rs2;
      logic [CW-1:0]      e_id;
      logic               e_full;
      logic [PW:0]        e_cnt;
   } vec_t;

   // clock / reset
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   register_renamer_ckpt_if #(.NUM_A_REGS(NA), .NUM_P_REGS(NP), .WIDTH(W), .NUM_CKPT(NC)) rn_if ();

   register_renamer_ckpt #(.NUM_A_REGS(NA), .NUM_P_REGS(NP), .WIDTH(W), .NUM_CKPT(NC)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .rn    (rn_if)
   );

   int n_vec;
   int n_checks;
   int n_fail;
   vec_t tbl [30];

   function automatic logic [1:0][AW-1:0] la(input int l0, input int l1);
      logic [1:0][AW-1:0] r;
      r[0] = l0[AW-1:0];
      r[1] = l1[AW-1:0];
      return r;
   endfunction

   function automatic logic [1:0][PW-1:0] pa(input int l0, input int l1);
      logic [1:0][PW-1:0] r;
      r[0] = l0[PW-1:0];
      r[1] = l1[PW-1:0];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      rn_if.ren_valid_i    = '0;
      rn_if.rd_i           = '0;
      rn_if.rs1_i          = '0;
      rn_if.rs2_i          = '0;
      rn_if.free_valid_i   = '0;
      rn_if.free_preg_i    = '0;
      rn_if.ckpt_take_i    = 1'b0;
      rn_if.ckpt_release_i = 1'b0;
      rn_if.recover_i      = 1'b0;
      rn_if.recover_id_i   = '0;
   endtask

   // drive one vector after the falling edge, check mid low phase
   task automatic apply(input vec_t v, input string name);
      @(negedge clk);
      rn_if.ren_valid_i    = v.valid;
      rn_if.rd_i           = v.rd;
      rn_if.rs1_i          = v.rs1;
      rn_if.rs2_i          = v.rs2;
      rn_if.free_valid_i   = v.fv;
      rn_if.free_preg_i    = v.fp;
      rn_if.ckpt_take_i    = v.take;
      rn_if.ckpt_release_i = v.rel;
      rn_if.recover_i      = v.rec;
      rn_if.recover_id_i   = v.rid;
      #2;
      n_vec++;
      chk({name, " ready"}, 32'(rn_if.ren_ready_o), 32'(v.e_ready));
      chk({name, " free_count"}, 32'(rn_if.free_count_o), 32'(v.e_cnt));
      chk({name, " ckpt_full"}, 32'(rn_if.ckpt_full_o), 32'(v.e_full));
      if (v.take && v.e_ready) chk({name, " ckpt_id"}, 32'(rn_if.ckpt_id_o), 32'(v.e_id));
      if (v.chk_ops) begin
         for (int k = 0; k < W; k++) begin
            chk($sformatf("%s p_dest[%0d]", name, k),   32'(rn_if.p_dest_o[k*PW +: PW]),   32'(v.e_pdest[k]));
            chk($sformatf("%s old_dest[%0d]", name, k), 32'(rn_if.old_dest_o[k*PW +: PW]), 32'(v.e_old[k]));
            chk($sformatf("%s p_rs1[%0d]", name, k),    32'(rn_if.p_rs1_o[k*PW +: PW]),    32'(v.e_rs1[k]));
            chk($sformatf("%s p_rs2[%0d]", name, k),    32'(rn_if.p_rs2_o[k*PW +: PW]),    32'(v.e_rs2[k]));
         end
      end
   endtask

   initial begin
      vec_t v;
      n_vec = 0;
      n_checks = 0;
      n_fail = 0;

      // valid rd rs1 rs2 fv fp take rel rec rid | chk ready pdest old rs1 rs2 id full cnt
      tbl[0]  = '{2'b00, la(7,0), la(1,31), la(2,0), 2'b00, pa(0,0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(7,0), pa(1,31), pa(2,0), 2'd0, 1'b0, 7'd32};
      tbl[1]  = '{2'b11, la(1,2), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(32,33), pa(1,2), pa(0,0), pa(0,0), 2'd0, 1'b0, 7'd32};
      tbl[2]  = '{2'b11, la(3,3), la(1,3), la(2,1), 2'b00, pa(0,0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(34,35), pa(3,34), pa(32,34), pa(33,32), 2'd0, 1'b0, 7'd30};
      tbl[3]  = '{2'b11, la(0,4), la(3,0), la(0,3), 2'b00, pa(0,0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,36), pa(0,4), pa(35,0), pa(0,35), 2'd0, 1'b0, 7'd28};
      tbl[4]  = '{2'b00, la(0,0), la(3,4), la(1,2), 2'b00, pa(0,0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(35,36), pa(32,33), 2'd0, 1'b0, 7'd27};
      // one free left: two-lane group stalls while register 32 comes back
      tbl[5]  = '{2'b11, la(10,11), la(0,0), la(0,0), 2'b01, pa(32,0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd0, 1'b0, 7'd1};
      tbl[6]  = '{2'b11, la(10,11), la(8,9), la(0,0), 2'b00, pa(0,0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(63,32), pa(10,11), pa(61,62), pa(0,0), 2'd0, 1'b0, 7'd2};
      tbl[7]  = '{2'b01, la(12,0), la(0,0), la(0,0), 2'b11, pa(3,34), 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd0, 1'b0, 7'd0};
      tbl[8]  = '{2'b00, la(0,0), la(10,11), la(0,0), 2'b11, pa(8,9), 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(63,32), pa(0,0), 2'd0, 1'b0, 7'd2};
      // checkpoint, rename past it, recover
      tbl[9]  = '{2'b11, la(5,6), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(3,34), pa(5,6), pa(0,0), pa(0,0), 2'd0, 1'b0, 7'd4};
      tbl[10] = '{2'b11, la(5,7), la(6,5), la(0,0), 2'b00, pa(0,0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(8,9), pa(3,7), pa(34,8), pa(0,0), 2'd0, 1'b0, 7'd2};
      tbl[11] = '{2'b11, la(1,2), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd0, 1'b0, 7'd0};
      tbl[12] = '{2'b00, la(0,0), la(5,7), la(6,0), 2'b00, pa(0,0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(3,7), pa(34,0), 2'd0, 1'b0, 7'd2};
      // fill the checkpoint queue, stall a fifth take, release one
      tbl[13] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd0, 1'b0, 7'd2};
      tbl[14] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd1, 1'b0, 7'd2};
      tbl[15] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd2, 1'b0, 7'd2};
      tbl[16] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd3, 1'b0, 7'd2};
      tbl[17] = '{2'b01, la(12,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd0, 1'b1, 7'd2};
      tbl[18] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd0, 1'b1, 7'd2};
      tbl[19] = '{2'b00, la(0,0), la(12,5), la(0,0), 2'b00, pa(0,0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(12,3), pa(0,0), 2'd0, 1'b0, 7'd2};
      // recovery wins over a same-cycle take and release
      tbl[20] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd0, 1'b0, 7'd2};
      tbl[21] = '{2'b00, la(0,0), la(5,7), la(0,0), 2'b00, pa(0,0), 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(3,7), pa(0,0), 2'd2, 1'b0, 7'd2};
      // after the mid-run reset
      tbl[22] = '{2'b00, la(3,0), la(5,7), la(1,2), 2'b00, pa(0,0), 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(3,0), pa(5,7), pa(1,2), 2'd0, 1'b0, 7'd32};
      tbl[23] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd0, 1'b0, 7'd32};
      tbl[24] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd0, 1'b0, 7'd32};
      tbl[25] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd1, 1'b0, 7'd32};
      tbl[26] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd2, 1'b0, 7'd32};
      tbl[27] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd3, 1'b0, 7'd32};
      tbl[28] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd0, 1'b0, 7'd32};
      tbl[29] = '{2'b00, la(0,0), la(0,0), la(0,0), 2'b00, pa(0,0), 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, pa(0,0), pa(0,0), pa(0,0), pa(0,0), 2'd0, 1'b1, 7'd32};

      // power-on reset
      rst = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i <= 4; i++) apply(tbl[i], $sformatf("v%0d", i));

      // drain 26 registers with rd={8,9} groups until one free entry remains
      for (int i = 0; i < 13; i++) begin
         v = tbl[4];
         v.valid   = 2'b11;
         v.rd      = la(8, 9);
         v.rs1     = la(0, 0);
         v.rs2     = la(0, 0);
         v.e_pdest = pa(37 + 2*i, 38 + 2*i);
         v.e_old   = (i == 0) ? pa(8, 9) : pa(35 + 2*i, 36 + 2*i);
         v.e_rs1   = pa(0, 0);
         v.e_rs2   = pa(0, 0);
         v.e_cnt   = 7'(27 - 2*i);
         apply(v, $sformatf("drain%0d", i));
      end

      for (int i = 5; i <= 21; i++) apply(tbl[i], $sformatf("v%0d", i));

      // reset in the middle of a group with take and frees pending
      @(negedge clk);
      rst = 1'b1;
      rn_if.ren_valid_i  = 2'b11;
      rn_if.rd_i         = la(1, 2);
      rn_if.ckpt_take_i  = 1'b1;
      rn_if.free_valid_i = 2'b11;
      rn_if.free_preg_i  = pa(40, 41);
      @(negedge clk);
      rst = 1'b0;
      drive_idle();

      for (int i = 22; i <= 29; i++) apply(tbl[i], $sformatf("v%0d", i));

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
